// File: rtl/epochtv1_vram_arb_if.sv
// Bus bundle between the TV-1 VRAM arbiter (slave) and its requesters/VRAM pins (master).
interface epochtv1_vram_arb_if;
  logic        CE;
  logic        ACTIVE;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [11:0] CPU_A;
  logic        CPU_LANE;
  logic [7:0]  CPU_DI;
  logic [7:0]  CPU_DO;
  logic        CPU_ACK;
  logic        BG_REQ;
  logic        SPR_REQ;
  logic [11:0] BG_A;
  logic [11:0] SPR_A;
  logic        BG_GNT;
  logic        SPR_GNT;
  logic        BG_DV;
  logic        SPR_DV;
  logic [11:0] VAA;
  logic [11:0] VBA;
  logic [7:0]  VAD_I;
  logic [7:0]  VBD_I;
  logic [7:0]  VAD_O;
  logic [7:0]  VBD_O;
  logic        nVARD;
  logic        nVBRD;
  logic        nVAWR;
  logic        nVBWR;
  logic [3:0]  dbg_cpu_wait;
  logic [1:0]  dbg_win;

  modport slave (
    input  CE, ACTIVE, CPU_REQ, CPU_WE, CPU_A, CPU_LANE, CPU_DI,
    input  BG_REQ, SPR_REQ, BG_A, SPR_A, VAD_I, VBD_I,
    output CPU_DO, CPU_ACK, BG_GNT, SPR_GNT, BG_DV, SPR_DV,
    output VAA, VBA, VAD_O, VBD_O, nVARD, nVBRD, nVAWR, nVBWR,
    output dbg_cpu_wait, dbg_win
  );

  modport master (
    output CE, ACTIVE, CPU_REQ, CPU_WE, CPU_A, CPU_LANE, CPU_DI,
    output BG_REQ, SPR_REQ, BG_A, SPR_A, VAD_I, VBD_I,
    input  CPU_DO, CPU_ACK, BG_GNT, SPR_GNT, BG_DV, SPR_DV,
    input  VAA, VBA, VAD_O, VBD_O, nVARD, nVBRD, nVAWR, nVBWR,
    input  dbg_cpu_wait, dbg_win
  );
endinterface

// File: rtl/epochtv1_vram_arb.sv
// Slot arbiter for Epoch TV-1 VRAM buses A/B: one access per CE slot, grant then data phase.
// Optional CPU starvation guard: define EPOCHTV1_VRAM_ARB_STARVE_GUARD_EN.
module epochtv1_vram_arb #(
  parameter int unsigned WAIT_MAX = 8
) (
  input logic                 CLK,
  input logic                 RSTB,
  epochtv1_vram_arb_if.slave  bus
);

  if (WAIT_MAX < 1 || WAIT_MAX > 15) begin : g_bad_wait_max
    $error("WAIT_MAX must be in 1..15");
  end

  // Handshake: REQ is a level sampled on CE edges; GNT marks the grant slot, and
  // DV/ACK pulse for exactly the following slot. Nothing changes without CE.
  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_BG   = 2'd1,
    WIN_SPR  = 2'd2,
    WIN_CPU  = 2'd3
  } win_e;

  win_e        win_q, win_d;
  logic        cpu_we_q, cpu_we_d;
  logic        cpu_lane_q, cpu_lane_d;
  logic [11:0] va_q, va_d;
  logic [7:0]  vad_o_q, vad_o_d;
  logic [7:0]  vbd_o_q, vbd_o_d;
  logic [7:0]  cpu_do_q, cpu_do_d;
  logic        nvard_q, nvard_d;
  logic        nvbrd_q, nvbrd_d;
  logic        nvawr_q, nvawr_d;
  logic        nvbwr_q, nvbwr_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        bg_dv_q, bg_dv_d;
  logic        spr_dv_q, spr_dv_d;
  logic        cpu_elig;
  logic        cpu_starved;

  // The CPU granted last slot is still in its data phase and cannot re-win yet.
  assign cpu_elig = bus.CPU_REQ && (win_q != WIN_CPU);

`ifdef EPOCHTV1_VRAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] WAIT_MAX_C = 4'(WAIT_MAX);
  logic [3:0] cpu_wait_q, cpu_wait_d;

  assign cpu_starved = cpu_elig && (cpu_wait_q == WAIT_MAX_C);

  always_comb begin
    cpu_wait_d = cpu_wait_q;
    if (bus.CE) begin
      if (!bus.CPU_REQ || win_d == WIN_CPU) begin
        cpu_wait_d = 4'd0;
      end else if (cpu_elig && cpu_wait_q != WAIT_MAX_C) begin
        cpu_wait_d = cpu_wait_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) cpu_wait_q <= 4'd0;
    else       cpu_wait_q <= cpu_wait_d;
  end

  assign bus.dbg_cpu_wait = cpu_wait_q;
`else
  assign cpu_starved      = 1'b0;
  assign bus.dbg_cpu_wait = 4'd0;
`endif

  always_comb begin
    win_d      = win_q;
    cpu_we_d   = cpu_we_q;
    cpu_lane_d = cpu_lane_q;
    va_d       = va_q;
    vad_o_d    = vad_o_q;
    vbd_o_d    = vbd_o_q;
    cpu_do_d   = cpu_do_q;
    nvard_d    = nvard_q;
    nvbrd_d    = nvbrd_q;
    nvawr_d    = nvawr_q;
    nvbwr_d    = nvbwr_q;
    cpu_ack_d  = cpu_ack_q;
    bg_dv_d    = bg_dv_q;
    spr_dv_d   = spr_dv_q;

    if (bus.CE) begin
      // Data phase of whatever was granted in the previous slot.
      bg_dv_d   = (win_q == WIN_BG);
      spr_dv_d  = (win_q == WIN_SPR);
      cpu_ack_d = (win_q == WIN_CPU);
      if (win_q == WIN_CPU && !cpu_we_q) begin
        cpu_do_d = cpu_lane_q ? bus.VBD_I : bus.VAD_I;
      end

      nvard_d = 1'b1;
      nvbrd_d = 1'b1;
      nvawr_d = 1'b1;
      nvbwr_d = 1'b1;

      win_d = WIN_NONE;
      if (cpu_starved) begin
        win_d = WIN_CPU;
      end else if (bus.ACTIVE) begin
        if      (bus.BG_REQ)  win_d = WIN_BG;
        else if (bus.SPR_REQ) win_d = WIN_SPR;
        else if (cpu_elig)    win_d = WIN_CPU;
      end else begin
        if      (cpu_elig)    win_d = WIN_CPU;
        else if (bus.SPR_REQ) win_d = WIN_SPR;
        else if (bus.BG_REQ)  win_d = WIN_BG;
      end

      case (win_d)
        WIN_BG: begin
          va_d    = bus.BG_A;
          nvard_d = 1'b0;
          nvbrd_d = 1'b0;
        end
        WIN_SPR: begin
          va_d    = bus.SPR_A;
          nvard_d = 1'b0;
          nvbrd_d = 1'b0;
        end
        WIN_CPU: begin
          va_d       = bus.CPU_A;
          cpu_we_d   = bus.CPU_WE;
          cpu_lane_d = bus.CPU_LANE;
          if (bus.CPU_WE) begin
            if (bus.CPU_LANE) begin
              nvbwr_d = 1'b0;
              vbd_o_d = bus.CPU_DI;
            end else begin
              nvawr_d = 1'b0;
              vad_o_d = bus.CPU_DI;
            end
          end else if (bus.CPU_LANE) begin
            nvbrd_d = 1'b0;
          end else begin
            nvard_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      win_q      <= WIN_NONE;
      cpu_we_q   <= 1'b0;
      cpu_lane_q <= 1'b0;
      va_q       <= 12'd0;
      vad_o_q    <= 8'd0;
      vbd_o_q    <= 8'd0;
      cpu_do_q   <= 8'd0;
      nvard_q    <= 1'b1;
      nvbrd_q    <= 1'b1;
      nvawr_q    <= 1'b1;
      nvbwr_q    <= 1'b1;
      cpu_ack_q  <= 1'b0;
      bg_dv_q    <= 1'b0;
      spr_dv_q   <= 1'b0;
    end else begin
      win_q      <= win_d;
      cpu_we_q   <= cpu_we_d;
      cpu_lane_q <= cpu_lane_d;
      va_q       <= va_d;
      vad_o_q    <= vad_o_d;
      vbd_o_q    <= vbd_o_d;
      cpu_do_q   <= cpu_do_d;
      nvard_q    <= nvard_d;
      nvbrd_q    <= nvbrd_d;
      nvawr_q    <= nvawr_d;
      nvbwr_q    <= nvbwr_d;
      cpu_ack_q  <= cpu_ack_d;
      bg_dv_q    <= bg_dv_d;
      spr_dv_q   <= spr_dv_d;
    end
  end

  assign bus.VAA     = va_q;
  assign bus.VBA     = va_q;
  assign bus.VAD_O   = vad_o_q;
  assign bus.VBD_O   = vbd_o_q;
  assign bus.CPU_DO  = cpu_do_q;
  assign bus.CPU_ACK = cpu_ack_q;
  assign bus.BG_GNT  = (win_q == WIN_BG);
  assign bus.SPR_GNT = (win_q == WIN_SPR);
  assign bus.BG_DV   = bg_dv_q;
  assign bus.SPR_DV  = spr_dv_q;
  assign bus.nVARD   = nvard_q;
  assign bus.nVBRD   = nvbrd_q;
  assign bus.nVAWR   = nvawr_q;
  assign bus.nVBWR   = nvbwr_q;
  assign bus.dbg_win = win_q;

endmodule
